fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the Core101 pipeline. The block owns the program counter and issues one instruction-memory request at a time, starting from the reset vector. Fetched words are buffered together with their PC in a two-entry queue and handed to decode over a valid/ready handshake. A redirect from execute (branch, jump or trap) flushes all fetched work and restarts fetch at the new address.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC and memory address width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset

Ports:
- fetch_clock_input  in  1  clock; all state updates on the rising edge
- fetch_reset_n_input  in  1  reset, asynchronous and active-low
- fetch_mem_req_valid  out  1  request to instruction memory
- fetch_mem_req_ready  in  1  memory accepts the request
- fetch_mem_req_addr  out  ADDR_WIDTH  request address (current PC)
- fetch_mem_rsp_valid  in  1  response data valid
- fetch_mem_rsp_data  in  DATA_WIDTH  fetched instruction
- fetch_redirect_valid  in  1  flush and restart fetch
- fetch_redirect_addr  in  ADDR_WIDTH  restart address
- fetch_out_valid  out  1  instruction available to decode
- fetch_out_ready  in  1  decode consumes the instruction
- fetch_out_pc  out  ADDR_WIDTH  PC of the presented instruction
- fetch_out_instr  out  DATA_WIDTH  presented instruction
- fetch_misalign_fault  out  1  present only with FETCH_MISALIGN_TRAP_EN

## Operation
- State machine with four states:
  - IDLE: entered on reset; lasts exactly one cycle after reset release, then goes to REQ.
  - REQ: req_valid=1. On req_valid & req_ready: PC <= PC+4, go to WAIT.
  - WAIT: waiting for a response. On rsp_valid: push {request address, rsp_data} into the queue. Go to REQ if credit is available, otherwise to HOLD.
  - DROP: waiting for a response that will be discarded. On rsp_valid: discard the data, go to REQ.
  - HOLD: the same encoding as REQ with req_valid=0. HOLD is not a separate state.
- Credit rule: a request may be issued only when (queue count + outstanding) < 2.
- At most one request is outstanding. rsp_valid is ignored in IDLE and REQ.
- The queue is two entries deep and first-word-fall-through. fetch_out_* always reflect the queue head; out_valid = (count != 0).
- A pop occurs on out_valid & out_ready. A push and a pop in the same cycle leave count unchanged.
- Redirect has the highest priority:
  - The queue is cleared and PC <= redirect_addr.
  - From WAIT, or from REQ with the request accepted in the same cycle: go to DROP.
  - From REQ without ready: stay in REQ. The next cycle presents the new address; the abandoned request is not counted.
  - A response arriving in the same cycle as a redirect is discarded.
- PC arithmetic is modulo 2^ADDR_WIDTH: PC+4 wraps from all-ones-minus-3 to 0.
- Reset values: req_valid=0, req_addr=RESET_VECTOR, out_valid=0, out_pc=0, out_instr=0, fault=0, queue empty.
- Reset mid-operation: all state clears immediately (asynchronous reset). Any response that arrives after reset release, while in IDLE, is ignored.

## Timing
- Request issue to response: rsp_valid earliest one cycle after acceptance; no upper bound.
- Response to decode: out_valid is high the cycle after rsp_valid (queue registered).
- Throughput: one instruction per two cycles with a zero-wait memory. Back-pressure from decode stops requests once the credit limit is reached.
- Redirect: out_valid=0 the cycle after redirect_valid. The new address appears on req_addr the cycle after the redirect, or after the pending response drains in DROP.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect_addr with bits [1:0] != 0 raises fetch_misalign_fault for one cycle.
  - No request is issued; the FSM parks in IDLE until the next aligned redirect.
- FETCH_MISALIGN_TRAP_EN undefined:
  - redirect_addr[1:0] is forced to 0.
  - No fault port exists.

## Structure
- Shared package core101_pkg holds:
  - the fetch FSM state enum (IDLE, REQ, WAIT, DROP);
  - the PC_STEP constant (4);
  - the default RESET_VECTOR.
- Sub-module fetch_queue: a two-entry FIFO of {pc, instr} with push, pop, flush and count.

## Test plan
- Reset release, RESET_VECTOR=0x100, memory ready every cycle with one-cycle latency: req_addr sequence is 0x100, 0x104, 0x108. Decode sees out_pc 0x100 with the matching instr on the third cycle after reset release.
- fetch_out_ready held low: after two responses, req_valid stays 0. Raising out_ready for one cycle yields exactly one new request.
- Redirect to 0x200 while in WAIT: the next response is dropped, out_valid stays 0, and the next req_addr is 0x200.
- Redirect asserted in the same cycle as rsp_valid and a pop: the queue becomes empty and no instruction from before the redirect reaches decode.
- PC at 0xFFFF_FFFC is accepted: the next req_addr is 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x202: the fault pulses for one cycle and req_valid stays 0 until a redirect to 0x300, after which req_addr is 0x300.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared Core101 definitions: fetch FSM state encoding, PC increment and default reset vector.
package core101_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_WAIT = 2'd2,
      FETCH_DROP = 2'd3
   } fetch_state_e;

   localparam int unsigned PC_STEP              = 4;
   localparam int unsigned FETCH_QUEUE_DEPTH    = 2;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: instruction-memory request/response, redirect and decode handshake.
// fetch_misalign_fault exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // the sender holds valid and its payload stable until then. rsp_valid has no ready.
   logic                  fetch_mem_req_valid;
   logic                  fetch_mem_req_ready;
   logic [ADDR_WIDTH-1:0] fetch_mem_req_addr;
   logic                  fetch_mem_rsp_valid;
   logic [DATA_WIDTH-1:0] fetch_mem_rsp_data;
   logic                  fetch_redirect_valid;
   logic [ADDR_WIDTH-1:0] fetch_redirect_addr;
   logic                  fetch_out_valid;
   logic                  fetch_out_ready;
   logic [ADDR_WIDTH-1:0] fetch_out_pc;
   logic [DATA_WIDTH-1:0] fetch_out_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic                  fetch_misalign_fault;
`endif

   modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
      output fetch_misalign_fault,
`endif
      output fetch_mem_req_valid, fetch_mem_req_addr,
      input  fetch_mem_req_ready, fetch_mem_rsp_valid, fetch_mem_rsp_data,
      input  fetch_redirect_valid, fetch_redirect_addr,
      output fetch_out_valid, fetch_out_pc, fetch_out_instr,
      input  fetch_out_ready
   );

   modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
      input  fetch_misalign_fault,
`endif
      input  fetch_mem_req_valid, fetch_mem_req_addr,
      output fetch_mem_req_ready, fetch_mem_rsp_valid, fetch_mem_rsp_data,
      output fetch_redirect_valid, fetch_redirect_addr,
      input  fetch_out_valid, fetch_out_pc, fetch_out_instr,
      output fetch_out_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry first-word-fall-through queue of {pc, instr}; entry 0 is always the head.
module fetch_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [ADDR_WIDTH-1:0] push_pc_i,
   input  logic [DATA_WIDTH-1:0] push_instr_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   output logic [1:0]            count_o,
   output logic [ADDR_WIDTH-1:0] head_pc_o,
   output logic [DATA_WIDTH-1:0] head_instr_o
);

   logic [ADDR_WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
   logic [DATA_WIDTH-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
   logic [1:0]            count_q, count_d, slot;
   logic                  do_pop, do_push;

   always_comb begin
      pc0_d    = pc0_q;
      pc1_d    = pc1_q;
      instr0_d = instr0_q;
      instr1_d = instr1_q;
      do_pop   = pop_i && (count_q != 2'd0);
      // Slot the incoming word lands in once the head (if popped) has shifted out.
      slot     = count_q - {1'b0, do_pop};
      do_push  = push_i && (slot != 2'd2);
      if (do_pop) begin
         pc0_d    = pc1_q;
         instr0_d = instr1_q;
      end
      if (do_push) begin
         if (slot == 2'd0) begin
            pc0_d    = push_pc_i;
            instr0_d = push_instr_i;
         end else begin
            pc1_d    = push_pc_i;
            instr1_d = push_instr_i;
         end
      end
      count_d = flush_i ? 2'd0 : slot + {1'b0, do_push};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc0_q    <= '0;
         pc1_q    <= '0;
         instr0_q <= '0;
         instr1_q <= '0;
         count_q  <= 2'd0;
      end else begin
         pc0_q    <= pc0_d;
         pc1_q    <= pc1_d;
         instr0_q <= instr0_d;
         instr1_q <= instr1_d;
         count_q  <= count_d;
      end
   end

   assign count_o      = count_q;
   assign head_pc_o    = pc0_q;
   assign head_instr_o = instr0_q;

endmodule

// File: rtl/fetch_unit.sv
// Core101 instruction fetch: owns the PC, keeps one memory request in flight and feeds decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN traps misaligned redirects instead of aligning them.
module fetch_unit
   import core101_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
   input  logic                fetch_clock_input,
   input  logic                fetch_reset_n_input,
   fetch_unit_if.master        bus,
   output logic [1:0]          dbg_state_o
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, redirect_pc;
   logic [1:0]            q_count;
   logic                  outstanding, credit_ok, req_fire, push, pop;
   logic                  park_hold, misaligned;

   assign outstanding             = (state_q == FETCH_WAIT) || (state_q == FETCH_DROP);
   assign credit_ok               = (q_count + {1'b0, outstanding}) < 2'(FETCH_QUEUE_DEPTH);
   assign bus.fetch_mem_req_valid = (state_q == FETCH_REQ) && credit_ok;
   assign bus.fetch_mem_req_addr  = pc_q;
   assign req_fire                = bus.fetch_mem_req_valid && bus.fetch_mem_req_ready;
   assign bus.fetch_out_valid     = (q_count != 2'd0);
   assign pop                     = bus.fetch_out_valid && bus.fetch_out_ready;
   assign dbg_state_o             = state_q;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic parked_q, parked_d, fault_q;

   assign misaligned               = bus.fetch_redirect_valid && (bus.fetch_redirect_addr[1:0] != 2'b00);
   assign redirect_pc              = bus.fetch_redirect_addr;
   assign park_hold                = parked_q;
   assign parked_d                 = bus.fetch_redirect_valid ? misaligned : parked_q;
   assign bus.fetch_misalign_fault = fault_q;

   always_ff @(posedge fetch_clock_input or negedge fetch_reset_n_input) begin
      if (!fetch_reset_n_input) begin
         parked_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         parked_q <= parked_d;
         fault_q  <= misaligned;
      end
   end
`else
   logic unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^bus.fetch_redirect_addr[1:0];
   assign misaligned           = 1'b0;
   assign redirect_pc          = {bus.fetch_redirect_addr[ADDR_WIDTH-1:2], 2'b00};
   assign park_hold            = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      case (state_q)
         FETCH_IDLE: if (!park_hold) state_d = FETCH_REQ;
         FETCH_REQ: if (req_fire) begin
            pc_d     = pc_q + ADDR_WIDTH'(PC_STEP);
            req_pc_d = pc_q;
            state_d  = FETCH_WAIT;
         end
         FETCH_WAIT: if (bus.fetch_mem_rsp_valid) begin
            push    = 1'b1;
            state_d = FETCH_REQ;
         end
         FETCH_DROP: if (bus.fetch_mem_rsp_valid) state_d = FETCH_REQ;
         default: state_d = FETCH_IDLE;
      endcase
      // Redirect wins over everything; a request still in flight must be drained in DROP.
      if (bus.fetch_redirect_valid) begin
         push = 1'b0;
         pc_d = redirect_pc;
         case (state_q)
            FETCH_WAIT, FETCH_DROP: state_d = bus.fetch_mem_rsp_valid ? FETCH_REQ : FETCH_DROP;
            FETCH_REQ:              state_d = req_fire ? FETCH_DROP : FETCH_REQ;
            default:                state_d = FETCH_REQ;
         endcase
         if (misaligned) begin
            pc_d    = pc_q;
            state_d = FETCH_IDLE;
         end
      end
   end

   always_ff @(posedge fetch_clock_input or negedge fetch_reset_n_input) begin
      if (!fetch_reset_n_input) begin
         state_q  <= FETCH_IDLE;
         pc_q     <= RESET_VECTOR;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   fetch_queue #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_queue (
      .clk_i       (fetch_clock_input),
      .rst_ni      (fetch_reset_n_input),
      .push_i      (push),
      .push_pc_i   (req_pc_q),
      .push_instr_i(bus.fetch_mem_rsp_data),
      .pop_i       (pop),
      .flush_i     (bus.fetch_redirect_valid),
      .count_o     (q_count),
      .head_pc_o   (bus.fetch_out_pc),
      .head_instr_o(bus.fetch_out_instr)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory/decode driver, expected-instruction queue, final report.
module tb_fetch_unit;
   import core101_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [AW-1:0] RV = 32'h0000_0100;

   // clock / reset
   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] dbg_state;
   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   fetch_unit #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .RESET_VECTOR(RV)
   ) dut (
      .fetch_clock_input  (clk),
      .fetch_reset_n_input(rst_n),
      .bus                (bus),
      .dbg_state_o        (dbg_state)
   );

   // scoreboard state
   logic [63:0]   exp_q[$];
   logic [AW-1:0] fire_log[$];
   logic [AW-1:0] pop_log[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   // memory / decode model state
   int            mem_lat   = 1;
   bit            mem_ready = 1'b1;
   bit            dec_ready = 1'b1;
   bit            redir     = 1'b0;
   bit            stray_rsp = 1'b0;
   logic [AW-1:0] redir_addr = '0;
   bit            pend      = 1'b0;
   bit            pend_drop = 1'b0;
   logic [AW-1:0] pend_addr = '0;
   int            pend_cnt  = 0;

   function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_inputs_idle();
      bus.fetch_mem_req_ready  = 1'b0;
      bus.fetch_mem_rsp_valid  = 1'b0;
      bus.fetch_mem_rsp_data   = '0;
      bus.fetch_redirect_valid = 1'b0;
      bus.fetch_redirect_addr  = '0;
      bus.fetch_out_ready      = 1'b0;
   endtask

   // One clock: drive at the falling edge, book-keep, cross the rising edge, return on the next fall.
   task automatic cycle();
      logic          rsp_now, fire;
      logic [AW-1:0] addr_now;
      logic [63:0]   exp;
      rsp_now = pend && (pend_cnt == 0);
      bus.fetch_mem_rsp_valid  = rsp_now || stray_rsp;
      bus.fetch_mem_rsp_data   = rsp_now ? instr_of(pend_addr) : 32'hDEAD_BEEF;
      bus.fetch_mem_req_ready  = mem_ready;
      bus.fetch_out_ready      = dec_ready;
      bus.fetch_redirect_valid = redir;
      bus.fetch_redirect_addr  = redir_addr;
      #1;
      check("out_valid_vs_model", {63'd0, bus.fetch_out_valid}, {63'd0, exp_q.size() != 0});
      fire     = bus.fetch_mem_req_valid && mem_ready;
      addr_now = bus.fetch_mem_req_addr;
      if (fire) begin
         fire_log.push_back(addr_now);
         check("one_outstanding", {63'd0, pend}, 64'd0);
      end
      if (redir) exp_q.delete();
      else if (bus.fetch_out_valid && dec_ready && exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         pop_log.push_back(bus.fetch_out_pc);
         check("pop_pc_instr", {bus.fetch_out_pc, bus.fetch_out_instr}, exp);
      end
      if (rsp_now && !redir && !pend_drop) exp_q.push_back({pend_addr, instr_of(pend_addr)});
      @(posedge clk);
      if (rsp_now) pend = 1'b0;
      else if (pend) begin
         pend_cnt--;
         if (redir) pend_drop = 1'b1;
      end
      if (fire) begin
         pend      = 1'b1;
         pend_addr = addr_now;
         pend_cnt  = mem_lat - 1;
         pend_drop = redir;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_inputs_idle();
      exp_q.delete();
      pend = 1'b0; pend_drop = 1'b0; redir = 1'b0; stray_rsp = 1'b0;
      #1;
      check("rst_req_valid", {63'd0, bus.fetch_mem_req_valid}, 64'd0);
      check("rst_req_addr", {32'd0, bus.fetch_mem_req_addr}, {32'd0, RV});
      check("rst_out_valid", {63'd0, bus.fetch_out_valid}, 64'd0);
      check("rst_out_pc", {32'd0, bus.fetch_out_pc}, 64'd0);
      check("rst_out_instr", {32'd0, bus.fetch_out_instr}, 64'd0);
      check("rst_state", {62'd0, dbg_state}, {62'd0, FETCH_IDLE});
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_fault", {63'd0, bus.fetch_misalign_fault}, 64'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic redirect_to(input logic [AW-1:0] a);
      redir = 1'b1; redir_addr = a;
      cycle();
      redir = 1'b0;
   endtask

   // directed sequence
   initial begin
      int k, n, np;
      drive_inputs_idle();
      @(negedge clk);
      do_reset();
      check("idle_after_release", {62'd0, dbg_state}, {62'd0, FETCH_IDLE});

      // reset-vector fetch, zero-wait memory with one-cycle response
      cycle();
      check("first_req_valid", {63'd0, bus.fetch_mem_req_valid}, 64'd1);
      check("first_req_addr", {32'd0, bus.fetch_mem_req_addr}, {32'd0, RV});
      cycle(); cycle();
      check("third_out_valid", {63'd0, bus.fetch_out_valid}, 64'd1);
      check("third_out_pc", {32'd0, bus.fetch_out_pc}, {32'd0, RV});
      check("third_out_instr", {32'd0, bus.fetch_out_instr}, {32'd0, instr_of(RV)});
      repeat (4) cycle();
      check("seq_addr0", {32'd0, fire_log[0]}, 64'h100);
      check("seq_addr1", {32'd0, fire_log[1]}, 64'h104);
      check("seq_addr2", {32'd0, fire_log[2]}, 64'h108);

      // decode back-pressure stops requests at the credit limit
      dec_ready = 1'b0;
      repeat (10) cycle();
      check("full_req_valid", {63'd0, bus.fetch_mem_req_valid}, 64'd0);
      n = fire_log.size();
      repeat (4) cycle();
      check("full_no_fire", n, fire_log.size());
      dec_ready = 1'b1;
      cycle();
      dec_ready = 1'b0;
      repeat (8) cycle();
      check("one_pop_one_req", n + 1, fire_log.size());

      // redirect while waiting on a slow response
      dec_ready = 1'b1; mem_lat = 3;
      repeat (6) cycle();
      dec_ready = 1'b0;
      k = 0;
      while (!(dbg_state == FETCH_WAIT && exp_q.size() == 1 && pend && pend_cnt > 0) && k < 40) begin
         cycle(); k++;
      end
      check("reach_wait_with_entry", {63'd0, k < 40}, 64'd1);
      redirect_to(32'h0000_0200);
      n = fire_log.size();
      check("redir_wait_out_valid", {63'd0, bus.fetch_out_valid}, 64'd0);
      check("redir_wait_state", {62'd0, dbg_state}, {62'd0, FETCH_DROP});
      dec_ready = 1'b1;
      k = 0;
      while (fire_log.size() == n && k < 20) begin cycle(); k++; end
      check("redir_wait_new_addr", {32'd0, fire_log[n]}, 64'h200);

      // redirect coinciding with a response and a pop
      mem_lat = 1; dec_ready = 1'b0;
      k = 0;
      while (!(dbg_state == FETCH_WAIT && bus.fetch_out_valid && pend && pend_cnt == 0) && k < 40) begin
         cycle(); k++;
      end
      check("reach_rsp_pop_point", {63'd0, k < 40}, 64'd1);
      dec_ready = 1'b1;
      np = pop_log.size();
      redirect_to(32'h0000_0300);
      n = fire_log.size();
      check("redir_rsp_out_valid", {63'd0, bus.fetch_out_valid}, 64'd0);
      check("redir_rsp_req_addr", {32'd0, bus.fetch_mem_req_addr}, 64'h300);
      repeat (6) cycle();
      check("redir_rsp_fire", {32'd0, fire_log[n]}, 64'h300);
      check("redir_rsp_first_pop", {32'd0, pop_log[np]}, 64'h300);

      // PC wraps modulo 2^32
      redirect_to(32'hFFFF_FFFC);
      n = fire_log.size();
      repeat (8) cycle();
      check("wrap_top", {32'd0, fire_log[n]}, 64'hFFFF_FFFC);
      check("wrap_zero", {32'd0, fire_log[n+1]}, 64'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_to(32'h0000_0202);
      check("fault_pulse_hi", {63'd0, bus.fetch_misalign_fault}, 64'd1);
      n = fire_log.size();
      cycle();
      check("fault_pulse_lo", {63'd0, bus.fetch_misalign_fault}, 64'd0);
      repeat (5) cycle();
      check("parked_req_valid", {63'd0, bus.fetch_mem_req_valid}, 64'd0);
      check("parked_no_fire", n, fire_log.size());
      redirect_to(32'h0000_0300);
      n = fire_log.size();
      repeat (4) cycle();
      check("unpark_addr", {32'd0, fire_log[n]}, 64'h300);
`else
      redirect_to(32'h0000_0206);
      n = fire_log.size();
      repeat (4) cycle();
      check("align_forced", {32'd0, fire_log[n]}, 64'h204);
`endif

      // asynchronous reset mid-operation; a stray response during IDLE is ignored
      repeat (3) cycle();
      do_reset();
      np = pop_log.size();
      stray_rsp = 1'b1;
      cycle();
      stray_rsp = 1'b0;
      repeat (6) cycle();
      check("post_reset_first_pop", {32'd0, pop_log[np]}, {32'd0, RV});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
